// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_cmd_issue : queues ALU commands, issues them to a registered ALU and
//                 captures Z/O into a tagged valid/ready result register.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module alu_cmd_issue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_z,
  output logic        res_o,
  output logic [3:0]  res_tag,
  output logic        busy,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic        AddorSub,
  output logic        ALUS0,
  output logic        ALUS1,
  output logic        L_R,
  input  logic [31:0] Z,
  input  logic        O
);

  localparam int c_AW      = $clog2(DEPTH);
  localparam int c_CNTW    = c_AW + 1;
  localparam int c_LATW    = $clog2(ALU_LAT + 1);
  localparam int c_ENTRY_W = 3 + 32 + 32;
  localparam logic [c_CNTW-1:0] c_FULL     = c_CNTW'(DEPTH);
  localparam logic [c_LATW-1:0] c_LAT_INIT = c_LATW'(ALU_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_CNTW-1:0]    r_count;

  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_addsub;
  logic              r_alus0;
  logic              r_alus1;
  logic              r_lr;
  logic [c_LATW-1:0] r_cnt;
  logic [3:0]        r_tag_cnt;
  logic [3:0]        r_issue_tag;
  logic              r_res_valid;
  logic [31:0]       r_res_z;
  logic              r_res_o;
  logic [3:0]        r_res_tag;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_capture;
  logic                 w_release;
  logic [c_ENTRY_W-1:0] w_head;
  logic [2:0]           w_head_op;
  logic [31:0]          w_head_a;
  logic [31:0]          w_head_b;

  assign w_full    = (r_count == c_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = cmd_valid && !w_full;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[66:64];
  assign w_head_a  = w_head[63:32];
  assign w_head_b  = w_head[31:0];

  // Command FIFO; a pop is always an issue, so w_issue doubles as the pop.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + c_CNTW'(1);
        2'b01:   r_count <= r_count - c_CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_release = 1'b1;
          if (!w_empty) begin
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_addsub    <= 1'b0;
      r_alus0     <= 1'b0;
      r_alus1     <= 1'b0;
      r_lr        <= 1'b0;
      r_cnt       <= '0;
      r_tag_cnt   <= '0;
      r_issue_tag <= '0;
      r_res_valid <= 1'b0;
      r_res_z     <= '0;
      r_res_o     <= 1'b0;
      r_res_tag   <= '0;
    end else begin
      if (w_issue) begin
        r_a         <= w_head_a;
        r_b         <= w_head_b;
        r_alus1     <= w_head_op[2];
        r_alus0     <= w_head_op[1];
        r_addsub    <= w_head_op[0] && (w_head_op[2:1] == 2'b00);
        r_lr        <= w_head_op[0] && (w_head_op[2:1] == 2'b10);
        r_cnt       <= c_LAT_INIT;
        r_issue_tag <= r_tag_cnt;
        r_tag_cnt   <= r_tag_cnt + 4'd1;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_LATW'(1);
      end
      if (w_capture) begin
        r_res_z     <= Z;
        r_res_o     <= O;
        r_res_tag   <= r_issue_tag;
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign res_valid = r_res_valid;
  assign res_z     = r_res_z;
  assign res_o     = r_res_o;
  assign res_tag   = r_res_tag;
  assign A         = r_a;
  assign B         = r_b;
  assign AddorSub  = r_addsub;
  assign ALUS0     = r_alus0;
  assign ALUS1     = r_alus1;
  assign L_R       = r_lr;

endmodule
`default_nettype wire
